ksa_gen: RTL and testbench

Parametrised RC4 key-scheduling engine: runs the 256-iteration swap loop of RC4 KSA over a single-port 256×8 S-box memory with a key of configurable byte length, tolerating a configurable memory read latency. It sits between the top-level controller (en/rdy handshake) and the S-box RAM, and is the next generation of the fixed 24-bit-key KSA block. Optionally it also performs the S[i]=i initialisation pass, so one request can take the S-box from arbitrary contents to a keyed state.

---
 rtl/ksa_gen_pkg.sv | 26 ++
 rtl/ksa_gen_if.sv | 18 +
 rtl/ksa_gen_key_sel.sv | 46 ++++
 rtl/ksa_gen.sv | 172 +++++++++++++++++
 tb/tb_ksa_gen.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ksa_gen_pkg.sv
// Shared constants and FSM state type for the RC4 key-scheduling engine.
// KSA_GEN_INIT_EN adds the S[i]=i initialisation state.
package ksa_gen_pkg;

  localparam int unsigned SBOX_DEPTH    = 256;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned MAX_KEY_BYTES = 32;
  localparam int unsigned KIDX_W        = $clog2(MAX_KEY_BYTES);
  localparam int unsigned WAIT_W        = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef KSA_GEN_INIT_EN
    ST_INIT,
`endif
    ST_RD_SI,
    ST_WAIT_SI,
    ST_CAP_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_CAP_SJ,
    ST_WR_I,
    ST_WR_J
  } ksa_state_e;

endpackage

// File: rtl/ksa_gen_if.sv
// Controller handshake plus S-box memory port of the key-scheduling engine.
interface ksa_gen_if #(
  parameter int unsigned KEY_BYTES = 3
);
  import ksa_gen_pkg::*;

  logic                        en;
  logic                        rdy;
  logic [BYTE_W*KEY_BYTES-1:0] key;
  logic [BYTE_W-1:0]           addr;
  logic [BYTE_W-1:0]           rddata;
  logic [BYTE_W-1:0]           wrdata;
  logic                        wren;

  modport master (output en, key, rddata, input rdy, addr, wrdata, wren);
  modport slave  (input en, key, rddata, output rdy, addr, wrdata, wren);

endinterface

// File: rtl/ksa_gen_key_sel.sv
// Latched key storage and wrapping key-byte index; byte 0 is the key MSB.
module ksa_key_sel
  import ksa_gen_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        advance,
  input  logic [BYTE_W*KEY_BYTES-1:0] key_in,
  output logic [BYTE_W-1:0]           key_byte
);

  logic [BYTE_W*KEY_BYTES-1:0] key_q, key_d;
  logic [KIDX_W-1:0]           kidx_q, kidx_d;

  always_comb begin
    key_d  = key_q;
    kidx_d = kidx_q;
    if (load) begin
      key_d  = key_in;
      kidx_d = '0;
    end else if (advance) begin
      kidx_d = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= '0;
      kidx_q <= '0;
    end else begin
      key_q  <= key_d;
      kidx_q <= kidx_d;
    end
  end

  always_comb begin
    key_byte = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIDX_W'(b)) key_byte = key_q[BYTE_W*(KEY_BYTES-1-b) +: BYTE_W];
    end
  end

endmodule

// File: rtl/ksa_gen.sv
// RC4 key-scheduling engine over a single-port 256x8 S-box with RD_LAT read latency.
// KSA_GEN_INIT_EN: each request first writes S[i]=i before scheduling.
module ksa_gen
  import ksa_gen_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned RD_LAT    = 1
) (
  input logic     clk,
  input logic     rst,
  ksa_gen_if.slave bus
);

  ksa_state_e        state_q, state_d;
  logic [8:0]        i_q, i_d;
  logic [BYTE_W-1:0] j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              rdy_q, rdy_d, wren_q, wren_d;
  logic [BYTE_W-1:0] addr_q, addr_d, wrdata_q, wrdata_d;
  logic              accept, advance;
  logic [BYTE_W-1:0] key_byte;

  ksa_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (advance),
    .key_in   (bus.key),
    .key_byte (key_byte)
  );

  // Memory-port registers are loaded on the edge that enters the state they
  // belong to, so addr/wren are already valid during that state's cycle.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    wcnt_d   = wcnt_q;
    rdy_d    = rdy_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = wren_q;
    accept   = 1'b0;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          accept = 1'b1;
          i_d    = '0;
          j_d    = '0;
          rdy_d  = 1'b0;
          addr_d = '0;
`ifdef KSA_GEN_INIT_EN
          state_d  = ST_INIT;
          wrdata_d = '0;
          wren_d   = 1'b1;
`else
          state_d  = ST_RD_SI;
          wren_d   = 1'b0;
`endif
        end
      end
`ifdef KSA_GEN_INIT_EN
      ST_INIT: begin
        if (i_q[7:0] == 8'hFF) begin
          i_d     = '0;
          addr_d  = '0;
          wren_d  = 1'b0;
          state_d = ST_RD_SI;
        end else begin
          i_d      = i_q + 9'd1;
          addr_d   = i_q[7:0] + 8'd1;
          wrdata_d = i_q[7:0] + 8'd1;
        end
      end
`endif
      ST_RD_SI: begin
        wcnt_d  = WAIT_W'(RD_LAT - 1);
        state_d = ST_WAIT_SI;
      end
      ST_WAIT_SI: begin
        if (wcnt_q == '0) begin
          si_d    = bus.rddata;
          j_d     = j_q + bus.rddata + key_byte;
          state_d = ST_CAP_SI;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end
      ST_CAP_SI: begin
        addr_d  = j_q;
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        wcnt_d  = WAIT_W'(RD_LAT - 1);
        state_d = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        if (wcnt_q == '0) begin
          sj_d    = bus.rddata;
          state_d = ST_CAP_SJ;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end
      ST_CAP_SJ: begin
        addr_d   = i_q[7:0];
        wrdata_d = sj_q;
        wren_d   = 1'b1;
        state_d  = ST_WR_I;
      end
      ST_WR_I: begin
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
        i_d      = i_q + 9'd1;
        advance  = 1'b1;
        state_d  = ST_WR_J;
      end
      ST_WR_J: begin
        wren_d = 1'b0;
        // i has already been advanced, so bit 8 marks the end of iteration 255
        if (i_q[8]) begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = i_q[7:0];
          state_d = ST_RD_SI;
        end
      end
      default: begin
        wren_d  = 1'b0;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      wcnt_q   <= '0;
      rdy_q    <= 1'b1;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      wcnt_q   <= wcnt_d;
      rdy_q    <= rdy_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;

endmodule

// File: tb/tb_ksa_gen.sv
// Bench for ksa_gen: two instances (1-byte key/RD_LAT=1, 3-byte key/RD_LAT=3),
// latency-exact S-box models and a write scoreboard fed by a software RC4 KSA.
`timescale 1ns/1ps
module tb_ksa_gen;
  import ksa_gen_pkg::*;

  localparam int unsigned KB_A = 1;
  localparam int unsigned RL_A = 1;
  localparam int unsigned KB_B = 3;
  localparam int unsigned RL_B = 3;
`ifdef KSA_GEN_INIT_EN
  localparam int unsigned INIT_CYC = 256;
  localparam int unsigned PRE_MODE = 2;
`else
  localparam int unsigned INIT_CYC = 0;
  localparam int unsigned PRE_MODE = 1;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned c0  = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ksa_gen_if #(.KEY_BYTES(KB_A)) ifa ();
  ksa_gen_if #(.KEY_BYTES(KB_B)) ifb ();

  ksa_gen #(.KEY_BYTES(KB_A), .RD_LAT(RL_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ksa_gen #(.KEY_BYTES(KB_B), .RD_LAT(RL_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  pipe_a [RL_A];
  logic [7:0]  pipe_b [RL_B];
  int unsigned pre_a = 0;
  int unsigned pre_b = 0;

  always @(posedge clk) begin
    if (pre_a != 0) begin
      for (int k = 0; k < 256; k++) mem_a[k] <= (pre_a == 1) ? 8'(k) : 8'hFF;
    end else if (ifa.wren === 1'b1) begin
      mem_a[ifa.addr] <= ifa.wrdata;
    end
    pipe_a[0] <= mem_a[ifa.addr];
    for (int k = 1; k < RL_A; k++) pipe_a[k] <= pipe_a[k-1];
  end
  assign ifa.rddata = pipe_a[RL_A-1];

  always @(posedge clk) begin
    if (pre_b != 0) begin
      for (int k = 0; k < 256; k++) mem_b[k] <= (pre_b == 1) ? 8'(k) : 8'hFF;
    end else if (ifb.wren === 1'b1) begin
      mem_b[ifb.addr] <= ifb.wrdata;
    end
    pipe_b[0] <= mem_b[ifb.addr];
    for (int k = 1; k < RL_B; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign ifb.rddata = pipe_b[RL_B-1];

  wr_t         q_a[$];
  wr_t         q_b[$];
  logic [7:0]  exp_s [2][256];
  int unsigned nwr [2];
  int unsigned ks_cyc [2][2];
  logic [7:0]  ks_ad [2][2];
  logic [7:0]  ks_dt [2][2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic on_write(input int id, input logic [7:0] a, input logic [7:0] d, input logic r);
    wr_t         e;
    int unsigned n;
    int unsigned pend;
    n    = nwr[id];
    pend = (id == 0) ? q_a.size() : q_b.size();
    check_eq($sformatf("wr_rdy_%0d", id), {31'd0, r}, 32'd0);
    if (pend == 0) begin
      check_eq($sformatf("unexpected_wr_%0d", id), 32'd1, 32'd0);
    end else begin
      e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
      check_eq($sformatf("wr_addr_%0d_n%0d", id, n), {24'd0, a}, {24'd0, e.a});
      check_eq($sformatf("wr_data_%0d_n%0d", id, n), {24'd0, d}, {24'd0, e.d});
    end
    if (n == INIT_CYC || n == INIT_CYC + 1) begin
      ks_cyc[id][n-INIT_CYC] = cyc - c0;
      ks_ad[id][n-INIT_CYC]  = a;
      ks_dt[id][n-INIT_CYC]  = d;
    end
    nwr[id] = n + 1;
  endtask

  always @(negedge clk) if (ifa.wren === 1'b1) on_write(0, ifa.addr, ifa.wrdata, ifa.rdy);
  always @(negedge clk) if (ifb.wren === 1'b1) on_write(1, ifb.addr, ifb.wrdata, ifb.rdy);

  task automatic push_model(input int id, input logic [39:0] key, input int unsigned kb);
    logic [7:0] s [256];
    logic [7:0] j, si, sj, kbyte;
    wr_t        e;
    j = 8'd0;
    for (int unsigned k = 0; k < 256; k++) begin
      s[k] = 8'(k);
      if (INIT_CYC != 0) begin
        e = '{a: 8'(k), d: 8'(k)};
        if (id == 0) q_a.push_back(e); else q_b.push_back(e);
      end
    end
    for (int unsigned i = 0; i < 256; i++) begin
      kbyte = key[8*(kb-1-(i%kb)) +: 8];
      si    = s[i];
      j     = j + si + kbyte;
      sj    = s[j];
      e = '{a: 8'(i), d: sj};
      if (id == 0) q_a.push_back(e); else q_b.push_back(e);
      e = '{a: j, d: si};
      if (id == 0) q_a.push_back(e); else q_b.push_back(e);
      s[i] = sj;
      s[j] = si;
    end
    exp_s[id] = s;
  endtask

  task automatic preload(input int id);
    @(negedge clk);
    if (id == 0) pre_a = PRE_MODE; else pre_b = PRE_MODE;
    @(negedge clk);
    pre_a = 0;
    pre_b = 0;
  endtask

  task automatic start(input int id, input logic [39:0] key);
    @(negedge clk);
    nwr[id] = 0;
    if (id == 0) begin
      ifa.key = key[KB_A*8-1:0];
      ifa.en  = 1'b1;
      push_model(0, key, KB_A);
    end else begin
      ifb.key = key[KB_B*8-1:0];
      ifb.en  = 1'b1;
      push_model(1, key, KB_B);
    end
    @(posedge clk);
    #1;
    c0     = cyc;
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    check_eq($sformatf("rdy_low_after_accept_%0d", id),
             {31'd0, (id == 0) ? ifa.rdy : ifb.rdy}, 32'd0);
  endtask

  task automatic busy_poke(input int id, input logic [39:0] key, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      if (id == 0) begin ifa.key = key[KB_A*8-1:0]; ifa.en = 1'b1; end
      else begin ifb.key = key[KB_B*8-1:0]; ifb.en = 1'b1; end
    end
    @(negedge clk);
    ifa.en = 1'b0;
    ifb.en = 1'b0;
  endtask

  task automatic wait_done(input int id, input int unsigned exp_cyc, input string tag);
    int unsigned t;
    logic        r;
    t = 0;
    r = 1'b0;
    while (t < exp_cyc + 100) begin
      @(negedge clk);
      r = (id == 0) ? ifa.rdy : ifb.rdy;
      if (r === 1'b1) break;
      t++;
    end
    if (r !== 1'b1) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    else check_eq({tag, "_latency"}, cyc - c0, exp_cyc);
  endtask

  task automatic check_sbox(input int id, input string tag);
    int unsigned bad;
    logic [7:0]  v;
    bad = 0;
    for (int unsigned k = 0; k < 256; k++) begin
      v = (id == 0) ? mem_a[k] : mem_b[k];
      if (v !== exp_s[id][k]) bad++;
    end
    check_eq({tag, "_bad_bytes"}, bad, 32'd0);
    check_eq({tag, "_pending"}, (id == 0) ? q_a.size() : q_b.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    check_eq("watchdog", 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.en = 1'b0; ifa.key = '0;
    ifb.en = 1'b0; ifb.key = '0;
    nwr[0] = 0; nwr[1] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdy_a",    {31'd0, ifa.rdy},  32'd1);
    check_eq("rst_wren_a",   {31'd0, ifa.wren}, 32'd0);
    check_eq("rst_addr_a",   {24'd0, ifa.addr}, 32'd0);
    check_eq("rst_wrdata_a", {24'd0, ifa.wrdata}, 32'd0);
    check_eq("rst_rdy_b",    {31'd0, ifb.rdy},  32'd1);
    check_eq("rst_wren_b",   {31'd0, ifb.wren}, 32'd0);
    check_eq("rst_addr_b",   {24'd0, ifb.addr}, 32'd0);
    check_eq("rst_wrdata_b", {24'd0, ifb.wrdata}, 32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("idle_writes_a", nwr[0], 32'd0);
    check_eq("idle_writes_b", nwr[1], 32'd0);
    check_eq("idle_rdy_a", {31'd0, ifa.rdy}, 32'd1);
    check_eq("idle_rdy_b", {31'd0, ifb.rdy}, 32'd1);

    // key 01: first swap writes S[0]=1 then S[1]=0
    preload(0);
    start(0, 40'h01);
    wait_done(0, 256 * (6 + 2 * RL_A) + INIT_CYC, "a_k01");
    check_sbox(0, "a_k01_sbox");
    check_eq("a_k01_w0_addr", {24'd0, ks_ad[0][0]}, 32'h00);
    check_eq("a_k01_w0_data", {24'd0, ks_dt[0][0]}, 32'h01);
    check_eq("a_k01_w1_addr", {24'd0, ks_ad[0][1]}, 32'h01);
    check_eq("a_k01_w1_data", {24'd0, ks_dt[0][1]}, 32'h00);
    check_eq("a_k01_w0_cycle", ks_cyc[0][0], INIT_CYC + 6);
    check_eq("a_k01_w1_cycle", ks_cyc[0][1], INIT_CYC + 7);

    // key 00: iteration 0 has i==j, address 0 written twice with S[0]
    preload(0);
    start(0, 40'h00);
    wait_done(0, 256 * (6 + 2 * RL_A) + INIT_CYC, "a_k00");
    check_sbox(0, "a_k00_sbox");
    check_eq("a_k00_w0_addr", {24'd0, ks_ad[0][0]}, 32'h00);
    check_eq("a_k00_w0_data", {24'd0, ks_dt[0][0]}, 32'h00);
    check_eq("a_k00_w1_addr", {24'd0, ks_ad[0][1]}, 32'h00);
    check_eq("a_k00_w1_data", {24'd0, ks_dt[0][1]}, 32'h00);

    // abort mid-run, then a clean request with en pokes while busy
    preload(0);
    start(0, 40'h01);
    repeat (700) @(negedge clk);
    q_a.delete();
    rst = 1'b1;
    #1;
    check_eq("abort_rdy_a",  {31'd0, ifa.rdy},  32'd1);
    check_eq("abort_wren_a", {31'd0, ifa.wren}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    preload(0);
    start(0, 40'h01);
    busy_poke(0, 40'hFF, 20);
    wait_done(0, 256 * (6 + 2 * RL_A) + INIT_CYC, "a_after_abort");
    check_sbox(0, "a_after_abort_sbox");

    preload(1);
    start(1, 40'h00033C);
    busy_poke(1, 40'hAAAAAA, 10);
    wait_done(1, 256 * (6 + 2 * RL_B) + INIT_CYC, "b_k33c");
    check_sbox(1, "b_k33c_sbox");
    check_eq("b_w0_cycle", ks_cyc[1][0], INIT_CYC + 4 + 2 * RL_B);
    check_eq("b_w1_cycle", ks_cyc[1][1], INIT_CYC + 5 + 2 * RL_B);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
